// File: rtl/riscv_fetch_unit.sv
// riscv_fetch_unit
// Instruction-fetch stage of the single-cycle RISC-V core. It owns the PC and
// fetches one instruction at a time over a variable-latency request/response
// handshake. It holds each fetched word for execute and selects the next PC
// (sequential or branch target) once execute has retired the word.
//
// Parameters:
//   RESET_PC - PC value loaded on reset
//   TIMEOUT  - maximum FETCH cycles without imem_rvalid before a bus error
//              (0 disables the timeout)
//   TO_W     - width of the timeout counter (TIMEOUT < 2**TO_W)
//
// Ports:
//   clk, rst_n          - rising-edge clock, asynchronous active-low reset
//   imem_req/imem_addr  - fetch request and its address (= PC)
//   imem_rdata/rvalid   - instruction word and its one-cycle response strobe
//   PCSrc/ImmExt        - branch decision and sign-extended offset
//   exe_ready           - execute has consumed the held instruction
//   Instr/instr_valid   - held instruction and its valid flag
//   PC/PCPlus4          - address of the held instruction and PC + 4
//   op/funct3/funct7    - decode fields taken from Instr
//   bus_err             - sticky fetch-timeout flag
//   misalign_err        - sticky misaligned-target flag (optional, see below)
//
// Optional feature: when RISCV_FETCH_MISALIGN_TRAP_EN is defined, a next PC
// that is not word aligned sets misalign_err and halts the unit. When the
// macro is undefined, bits [1:0] of the next PC are forced to zero.
module riscv_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16,
  parameter int unsigned TO_W     = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_rvalid,
  input  logic        PCSrc,
  input  logic [31:0] ImmExt,
  input  logic        exe_ready,
  output logic [31:0] Instr,
  output logic        instr_valid,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic [6:0]  op,
  output logic [2:0]  funct3,
  output logic        funct7,
  output logic        bus_err
`ifdef RISCV_FETCH_MISALIGN_TRAP_EN
  ,
  output logic        misalign_err
`endif
);

  localparam logic [31:0]     NOP     = 32'h0000_0013;
  localparam bit              TO_EN   = (TIMEOUT != 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [TO_W-1:0] to_cnt;
  logic [31:0]     pc_target;
  logic [31:0]     pc_next;
  logic            capture;
  logic            retire;
  logic            timeout_hit;
  logic            misalign_hit;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and the handshake/datapath strobes
  always_comb begin
    state_next   = state;
    imem_req     = 1'b0;
    instr_valid  = 1'b0;
    capture      = 1'b0;
    retire       = 1'b0;
    timeout_hit  = 1'b0;
    misalign_hit = 1'b0;
    pc_target    = PC + (PCSrc ? ImmExt : 32'd4);

    case (state)
      IDLE: begin
        state_next = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        // A response in the expiry cycle still counts as a good fetch.
        if (imem_rvalid) begin
          capture    = 1'b1;
          state_next = ISSUE;
        end else if (TO_EN && (to_cnt == TO_LAST)) begin
          timeout_hit = 1'b1;
          state_next  = HALT;
        end
      end
      ISSUE: begin
        instr_valid = 1'b1;
        if (exe_ready) begin
`ifdef RISCV_FETCH_MISALIGN_TRAP_EN
          if (pc_target[1:0] != 2'b00) begin
            misalign_hit = 1'b1;
            state_next   = HALT;
          end else begin
            retire     = 1'b1;
            state_next = FETCH;
          end
`else
          retire     = 1'b1;
          state_next = FETCH;
`endif
        end
      end
      HALT: begin
        state_next = HALT;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // In the trap build the mask is a no-op, because only aligned targets are
  // ever loaded.
  assign pc_next = pc_target & 32'hFFFF_FFFC;

  // PC, instruction register, timeout counter and sticky error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PC           <= RESET_PC;
      Instr        <= NOP;
      to_cnt       <= '0;
      bus_err      <= 1'b0;
`ifdef RISCV_FETCH_MISALIGN_TRAP_EN
      misalign_err <= 1'b0;
`endif
    end else begin
      if (imem_req && !capture) begin
        to_cnt <= to_cnt + TO_W'(1);
      end else begin
        to_cnt <= '0;
      end
      if (capture) begin
        Instr <= imem_rdata;
      end
      if (retire) begin
        PC <= pc_next;
      end
      if (timeout_hit) begin
        bus_err <= 1'b1;
      end
`ifdef RISCV_FETCH_MISALIGN_TRAP_EN
      if (misalign_hit) begin
        misalign_err <= 1'b1;
      end
`endif
    end
  end

  assign imem_addr = PC;
  assign PCPlus4   = PC + 32'd4;
  assign op        = Instr[6:0];
  assign funct3    = Instr[14:12];
  assign funct7    = Instr[30];

endmodule
